apb_uart_sched: RTL and testbench
=================================

APB_UART_SCHED -- requirements
Module: apb_uart_sched

Interface
REQ-001 Parameter CFG_BAUD, 2'b10: baud code written to the UART config register after reset.
REQ-002 Parameter CFG_PARITY, 2'b01: parity code written to the UART config register after reset.
REQ-003 Parameter TIMEOUT, 16'd4095: maximum cycles spent in WAIT_DONE before abort.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  2  per-requester transmit request, level, held until its gnt.
REQ-007 req_data0 / req_data1  input  8 each  byte to transmit for requester 0 / 1.
REQ-008 apb_ready  input  1  APB transfer complete, from the APB/UART subsystem.
REQ-009 apb_error  input  1  APB slave error, valid only with apb_ready.
REQ-010 uart_tx_done  input  1  UART transmitter frame-complete pulse.
REQ-011 apb_en  output  1  APB transfer request.
REQ-012 apb_sel  output  2  APB slave select; 2'b01 during transfers, else 2'b00.
REQ-013 apb_addr  output  5  APB register address.
REQ-014 apb_write  output  1  APB write control; always 1 during transfers.
REQ-015 apb_wdata  output  32  APB write data.
REQ-016 gnt  output  2  one-hot, one-cycle completion pulse to the served requester.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 err  output  1  sticky error flag, cleared only by reset.

Function
REQ-019 Register map SHALL be: 5'h00 config {26'b0, CFG_PARITY, CFG_BAUD, 2'b00}, 5'h04 TX data {24'b0, byte}, 5'h08 control {31'b0, 1'b1} (send).
REQ-020 States SHALL be CFG, IDLE, WR_DATA, WR_SEND, WAIT_DONE, ACK, ERR.
REQ-021 Write states (CFG, WR_DATA, WR_SEND): apb_en=1, apb_sel=2'b01, apb_write=1, addr/wdata held stable until apb_ready=1 is sampled.
REQ-022 In a write state, apb_ready=1 with apb_error=1 SHALL go to ERR; apb_ready=1 with apb_error=0 SHALL advance: CFG->IDLE, WR_DATA->WR_SEND, WR_SEND->WAIT_DONE.
REQ-023 Outside write states apb_en=0, apb_sel=2'b00, apb_write=0, apb_addr=0, apb_wdata=0.
REQ-024 IDLE with any req bit set SHALL select a requester, latch its byte and index, and go to WR_DATA the next cycle.
REQ-025 Arbitration SHALL be round-robin: single request wins; both requesting, the requester not served last wins; after reset requester 0 has priority.
REQ-026 Last-served pointer SHALL update only on entering ACK.
REQ-027 Latched byte SHALL be unaffected by req_data changes after selection.
REQ-028 WAIT_DONE SHALL go to ACK on uart_tx_done=1; uart_tx_done outside WAIT_DONE SHALL be ignored.
REQ-029 WAIT_DONE SHALL count cycles from 0; reaching TIMEOUT without uart_tx_done SHALL go to ERR.
REQ-030 ACK SHALL last exactly one cycle, pulse gnt[index]=1, then go to IDLE; gnt SHALL be 0 in all other states.
REQ-031 ERR SHALL set err=1, pulse no gnt, drop the current byte and go to IDLE the next cycle; later requests are still served.
REQ-032 Minimum per-byte latency, IDLE request to gnt, with single-cycle apb_ready and immediate uart_tx_done: 5 cycles.

Reset
REQ-033 reset=1 SHALL force state CFG, gnt=0, err=0, busy=1, timeout count 0, pointer favoring requester 0, latched byte/index 0.
REQ-034 Reset asserted mid-operation SHALL abandon the transfer with no gnt pulse and restart at CFG.
REQ-035 After reset deassertion, config write SHALL be issued before any requester is served; requests during CFG SHALL wait.

Verification
REQ-036 Release reset, apb_ready=1 at once -> one write addr 5'h00 wdata 32'h00000018 (defaults), then IDLE, busy=0.
REQ-037 req=2'b01, req_data0=8'hA5 -> writes 5'h04/32'h000000A5, then 5'h08/32'h00000001; tx_done -> gnt=2'b01 one cycle.
REQ-038 req=2'b11 held for three bytes -> gnt order 01, 10, 01.
REQ-039 apb_ready=1 with apb_error=1 on the data write -> err=1, no gnt, IDLE; next request completes normally, err stays 1.
REQ-040 No uart_tx_done for TIMEOUT=16 cycles -> ERR after 16 WAIT_DONE cycles, err=1, no gnt.
REQ-041 reset pulsed during WAIT_DONE -> no gnt, err=0, config write reissued.

Source files
------------

// File: rtl/apb_uart_sched.sv
// Round-robin byte scheduler driving a UART through APB register writes.
// Configures the UART once after reset, then serves two requesters.
module apb_uart_sched #(
  parameter logic [1:0]  CFG_BAUD   = 2'b10,
  parameter logic [1:0]  CFG_PARITY = 2'b01,
  parameter logic [15:0] TIMEOUT    = 16'd4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [7:0]  req_data0,
  input  logic [7:0]  req_data1,
  input  logic        apb_ready,
  input  logic        apb_error,
  input  logic        uart_tx_done,
  output logic        apb_en,
  output logic [1:0]  apb_sel,
  output logic [4:0]  apb_addr,
  output logic        apb_write,
  output logic [31:0] apb_wdata,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    CFG, IDLE, WR_DATA, WR_SEND, WAIT_DONE, ACK, ERR
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt;
  logic        last;
  logic        idx;
  logic [7:0]  data;
  logic        pick;
  logic        tmo_hit;

  // On contention the requester not served last wins.
  always_comb begin
    if (req == 2'b11) pick = ~last;
    else              pick = req[1];
  end

  assign tmo_hit = ({1'b0, cnt} + 17'd1) >= {1'b0, TIMEOUT};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CFG;
      cnt   <= '0;
      last  <= 1'b1;
      idx   <= 1'b0;
      data  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req != 2'b00) begin
        idx  <= pick;
        data <= pick ? req_data1 : req_data0;
      end
      if (state == WAIT_DONE) cnt <= cnt + 16'd1;
      else                    cnt <= '0;
      if (state_n == ACK) last <= idx;
      if (state_n == ERR) err  <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      CFG: begin
        if (apb_ready) state_n = apb_error ? ERR : IDLE;
      end
      IDLE: begin
        if (req != 2'b00) state_n = WR_DATA;
      end
      WR_DATA: begin
        if (apb_ready) state_n = apb_error ? ERR : WR_SEND;
      end
      WR_SEND: begin
        if (apb_ready) state_n = apb_error ? ERR : WAIT_DONE;
      end
      WAIT_DONE: begin
        if (uart_tx_done) state_n = ACK;
        else if (tmo_hit) state_n = ERR;
      end
      ACK:     state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = CFG;
    endcase
  end

  always_comb begin
    apb_en    = 1'b0;
    apb_sel   = 2'b00;
    apb_write = 1'b0;
    apb_addr  = 5'h00;
    apb_wdata = 32'h0;
    gnt       = 2'b00;
    busy      = (state != IDLE);
    unique case (state)
      CFG: begin
        apb_en    = 1'b1;
        apb_sel   = 2'b01;
        apb_write = 1'b1;
        apb_addr  = 5'h00;
        apb_wdata = {26'b0, CFG_PARITY, CFG_BAUD, 2'b00};
      end
      WR_DATA: begin
        apb_en    = 1'b1;
        apb_sel   = 2'b01;
        apb_write = 1'b1;
        apb_addr  = 5'h04;
        apb_wdata = {24'b0, data};
      end
      WR_SEND: begin
        apb_en    = 1'b1;
        apb_sel   = 2'b01;
        apb_write = 1'b1;
        apb_addr  = 5'h08;
        apb_wdata = 32'h1;
      end
      ACK:     gnt = idx ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_uart_sched.sv
// Randomized bench for apb_uart_sched against a behavioural
// round-robin / sticky-error model.
module tb_apb_uart_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [7:0]  req_data0, req_data1;
  logic        apb_ready, apb_error, uart_tx_done;
  logic        apb_en, apb_write, busy, err;
  logic [1:0]  apb_sel, gnt;
  logic [4:0]  apb_addr;
  logic [31:0] apb_wdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_uart_sched #(.TIMEOUT(16'd16)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_data0(req_data0), .req_data1(req_data1),
    .apb_ready(apb_ready), .apb_error(apb_error),
    .uart_tx_done(uart_tx_done),
    .apb_en(apb_en), .apb_sel(apb_sel), .apb_addr(apb_addr),
    .apb_write(apb_write), .apb_wdata(apb_wdata),
    .gnt(gnt), .busy(busy), .err(err)
  );

  // Model: last-served requester, sticky error.
  int m_last;
  bit m_err;

  function automatic int m_pick(input logic [1:0] r);
    if (r == 2'b11) return (m_last == 0) ? 1 : 0;
    return r[1] ? 1 : 0;
  endfunction

  logic [4:0]  ob_addr;
  logic [31:0] ob_wdata;
  bit          ob_ok, ob_stable;

  logic [4:0]  r_a0, r_a1;
  logic [31:0] r_d0, r_d1;
  bit          r_ok, r_stable;
  logic [1:0]  r_gnt, r_after_gnt;
  logic        r_after_busy;
  int          r_gnt_i, r_err_i, r_lat;

  // Acts as the APB slave for one write; scrambles req_data once the
  // write is visible to show the byte was already latched.
  task automatic apb_accept(input bit error, input int delay);
    ob_ok = 0;
    ob_stable = 1;
    for (int i = 0; i < 50; i++) begin
      if (apb_en && apb_sel == 2'b01 && apb_write) begin
        ob_ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ob_ok) return;
    ob_addr = apb_addr;
    ob_wdata = apb_wdata;
    req_data0 = 8'($urandom_range(0, 255));
    req_data1 = 8'($urandom_range(0, 255));
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (!apb_en || apb_addr !== ob_addr || apb_wdata !== ob_wdata)
        ob_stable = 0;
    end
    apb_ready = 1;
    apb_error = error;
    @(negedge clk);
    apb_ready = 0;
    apb_error = 0;
  endtask

  task automatic run_byte(input bit e_data, input bit e_send,
                          input bit tmo, input bit zero, input bit drop);
    int start, d;
    start = cyc;
    r_gnt = 0; r_after_gnt = 0; r_after_busy = 1;
    r_gnt_i = -1; r_err_i = -1; r_lat = -1;
    r_a1 = 0; r_d1 = 0;
    apb_accept(e_data, zero ? 0 : $urandom_range(0, 2));
    r_ok = ob_ok; r_stable = ob_stable;
    r_a0 = ob_addr; r_d0 = ob_wdata;
    if (!e_data) begin
      apb_accept(e_send, zero ? 0 : $urandom_range(0, 2));
      r_ok &= ob_ok; r_stable &= ob_stable;
      r_a1 = ob_addr; r_d1 = ob_wdata;
    end
    d = zero ? 0 : $urandom_range(0, 5);
    for (int i = 0; i < 40; i++) begin
      if (err && r_err_i < 0) r_err_i = i;
      if (gnt != 2'b00) begin
        r_gnt = gnt; r_gnt_i = i; r_lat = cyc - start;
        if (drop) req = req & ~gnt;
        @(negedge clk);
        r_after_gnt = gnt; r_after_busy = busy;
        return;
      end
      if (i > 0 && !busy) return;
      if (!tmo && !e_data && !e_send && i == d) uart_tx_done = 1;
      @(negedge clk);
      uart_tx_done = 0;
    end
  endtask

  task automatic test_reset;
    reset = 1; req = 0; apb_ready = 0; apb_error = 0; uart_tx_done = 0;
    req_data0 = 0; req_data1 = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1 || gnt !== 2'b00 || err !== 0) begin
      errors++;
      $display("FAIL reset_outs: busy=%b gnt=%b err=%b want 1 00 0",
               busy, gnt, err);
    end
    reset = 0;
    m_last = 1; m_err = 0;
    apb_accept(0, $urandom_range(0, 3));
    checks++;
    if (!ob_ok || ob_addr !== 5'h00 || ob_wdata !== 32'h18 || !ob_stable) begin
      errors++;
      $display("FAIL cfg_write: ok=%0d addr=%h data=%h stable=%0d want 00 00000018",
               ob_ok, ob_addr, ob_wdata, ob_stable);
    end
    checks++;
    if (busy !== 0 || apb_en !== 0 || apb_sel !== 2'b00 || apb_write !== 0
        || apb_addr !== 5'h0 || apb_wdata !== 32'h0) begin
      errors++;
      $display("FAIL idle_outs: busy=%b en=%b sel=%b wr=%b addr=%h data=%h want all 0",
               busy, apb_en, apb_sel, apb_write, apb_addr, apb_wdata);
    end
  endtask

  task automatic test_single;
    logic [1:0] r;
    logic [7:0] b;
    int ix;
    for (int k = 0; k < 4; k++) begin
      r = (k == 0) ? 2'b01 : 2'($urandom_range(1, 2));
      req_data0 = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      req_data1 = 8'($urandom_range(0, 255));
      ix = m_pick(r);
      b = ix ? req_data1 : req_data0;
      req = r;
      run_byte(0, 0, 0, k == 0, 1);
      checks++;
      if (!r_ok || !r_stable || r_a0 !== 5'h04 || r_d0 !== {24'b0, b}
          || r_a1 !== 5'h08 || r_d1 !== 32'h1) begin
        errors++;
        $display("FAIL single_writes[%0d]: %h/%h %h/%h ok=%0d st=%0d want 04/%h 08/1",
                 k, r_a0, r_d0, r_a1, r_d1, r_ok, r_stable, b);
      end
      checks++;
      if (r_gnt !== 2'(1 << ix) || r_after_gnt !== 2'b00 || r_after_busy !== 0) begin
        errors++;
        $display("FAIL single_gnt[%0d]: gnt=%b next=%b busy=%b want %b 00 0",
                 k, r_gnt, r_after_gnt, r_after_busy, 2'(1 << ix));
      end
      if (k == 0) begin
        checks++;
        if (r_lat !== 4) begin
          errors++;
          $display("FAIL latency: got %0d edges want 4", r_lat);
        end
      end
      if (r_gnt != 0) m_last = ix;
    end
  endtask

  task automatic test_back_to_back;
    int ix;
    logic [7:0] b;
    m_last = 1;
    reset = 1;
    @(negedge clk);
    reset = 0;
    apb_accept(0, 0);
    req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      ix = m_pick(req);
      b = ix ? req_data1 : req_data0;
      run_byte(0, 0, 0, 0, 0);
      checks++;
      if (r_gnt !== 2'(1 << ix) || r_d0 !== {24'b0, b}) begin
        errors++;
        $display("FAIL b2b_order[%0d]: gnt=%b data=%h want %b %h",
                 k, r_gnt, r_d0, 2'(1 << ix), b);
      end
      m_last = ix;
    end
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_timeout;
    int ix;
    logic [7:0] b;
    req = 2'($urandom_range(1, 2));
    ix = m_pick(req);
    run_byte(0, 0, 1, 0, 1);
    checks++;
    if (r_err_i !== 16 || r_gnt !== 2'b00) begin
      errors++;
      $display("FAIL timeout: err_at=%0d gnt=%b want 16 00", r_err_i, r_gnt);
    end
    m_err = 1;
    b = ix ? req_data1 : req_data0;
    run_byte(0, 0, 0, 0, 1);
    checks++;
    if (r_gnt !== 2'(1 << ix) || r_d0 !== {24'b0, b} || err !== m_err) begin
      errors++;
      $display("FAIL timeout_retry: gnt=%b data=%h err=%b want %b %h %b",
               r_gnt, r_d0, err, 2'(1 << ix), b, m_err);
    end
    if (r_gnt != 0) m_last = ix;
  endtask

  task automatic test_error;
    int ix;
    logic [7:0] b;
    req = 2'b11;
    ix = m_pick(req);
    run_byte(1, 0, 0, 0, 0);
    checks++;
    if (r_gnt !== 2'b00 || r_err_i !== 0 || r_a0 !== 5'h04) begin
      errors++;
      $display("FAIL err_data: gnt=%b err_at=%0d addr=%h want 00 0 04",
               r_gnt, r_err_i, r_a0);
    end
    run_byte(0, 1, 0, 0, 0);
    checks++;
    if (r_gnt !== 2'b00 || r_a1 !== 5'h08) begin
      errors++;
      $display("FAIL err_send: gnt=%b addr=%h want 00 08", r_gnt, r_a1);
    end
    for (int k = 0; k < 2; k++) begin
      ix = m_pick(req);
      b = ix ? req_data1 : req_data0;
      run_byte(0, 0, 0, 0, 1);
      checks++;
      if (r_gnt !== 2'(1 << ix) || r_d0 !== {24'b0, b} || err !== 1) begin
        errors++;
        $display("FAIL err_recover[%0d]: gnt=%b data=%h err=%b want %b %h 1",
                 k, r_gnt, r_d0, err, 2'(1 << ix), b);
      end
      m_last = ix;
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    req_data0 = 8'($urandom_range(0, 255));
    req = 2'b01;
    apb_accept(0, 0);
    apb_accept(0, 0);
    repeat (3) @(negedge clk);
    reset = 1;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (gnt != 0) seen = 1;
    end
    reset = 0;
    checks++;
    if (seen || err !== 0 || busy !== 1) begin
      errors++;
      $display("FAIL mid_reset: gnt_seen=%0d err=%b busy=%b want 0 0 1",
               seen, err, busy);
    end
    m_last = 1; m_err = 0;
    apb_accept(0, $urandom_range(0, 2));
    checks++;
    if (!ob_ok || ob_addr !== 5'h00 || ob_wdata !== 32'h18) begin
      errors++;
      $display("FAIL mid_cfg: ok=%0d addr=%h data=%h want 00 00000018",
               ob_ok, ob_addr, ob_wdata);
    end
    run_byte(0, 0, 0, 0, 1);
    checks++;
    if (r_gnt !== 2'b01 || r_d0 !== {24'b0, req_data0} && 0 || err !== 0) begin
      errors++;
      $display("FAIL mid_serve: gnt=%b err=%b want 01 0", r_gnt, err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
